// File: rtl/mem_port_arbiter.sv
// Arbiter for the unified memory port shared by instruction fetch and MEM-stage loads/stores.
// Optional access timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_read,
  input  logic        d_write,
  input  logic        d_byte,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

  state_t      r_state, w_next;
  logic        r_last_data;
  logic        r_if_refused;
  logic [1:0]  r_lane;
  logic        r_byte;
  logic        w_d_req, w_grant_d, w_grant_f;
  logic        w_ack, w_abort, w_done;
  logic [7:0]  w_lane_byte;
  logic        w_unused;

  assign w_unused = ^if_addr[1:0];
  assign w_d_req  = d_read | d_write;
  assign w_ack    = m_ack & m_req;
  assign w_done   = w_ack | w_abort;

  // Fetch only beats data when it lost the previous arbitration to data.
  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_f = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_req && !(if_req && r_last_data && r_if_refused)) begin
          w_grant_d = 1'b1;
          w_next    = DATA;
        end else if (if_req) begin
          w_grant_f = 1'b1;
          w_next    = FETCH;
        end
      end
      DATA, FETCH: if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_data  <= 1'b0;
      r_if_refused <= 1'b0;
      r_lane       <= '0;
      r_byte       <= 1'b0;
      m_req        <= 1'b0;
      m_we         <= 1'b0;
      m_wstrb      <= '0;
      m_addr       <= '0;
      m_wdata      <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_d) begin
        m_req        <= 1'b1;
        m_we         <= d_write;
        m_addr       <= {d_addr[31:2], 2'b00};
        m_wstrb      <= d_write ? (d_byte ? (4'b0001 << d_addr[1:0]) : 4'b1111) : 4'b0000;
        m_wdata      <= d_byte ? {4{d_wdata[7:0]}} : d_wdata;
        r_lane       <= d_addr[1:0];
        r_byte       <= d_byte;
        r_last_data  <= 1'b1;
        r_if_refused <= if_req;
      end else if (w_grant_f) begin
        m_req        <= 1'b1;
        m_we         <= 1'b0;
        m_addr       <= {if_addr[31:2], 2'b00};
        m_wstrb      <= '0;
        m_wdata      <= '0;
        r_last_data  <= 1'b0;
        r_if_refused <= 1'b0;
      end else if (w_done) begin
        m_req <= 1'b0;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [31:0] r_cnt;

  // An ack arriving on the timeout cycle completes normally.
  assign w_abort = (r_state != IDLE) && !w_ack && (r_cnt == 32'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      err   <= 1'b0;
    end else begin
      err <= w_abort;
      if (w_grant_d || w_grant_f) r_cnt <= '0;
      else if ((r_state != IDLE) && !w_ack) r_cnt <= r_cnt + 32'd1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = TIMEOUT[0];
  assign w_abort          = 1'b0;
  assign err              = 1'b0;
`endif

  assign w_lane_byte = m_rdata[{r_lane, 3'b000} +: 8];

  assign if_valid  = (r_state == FETCH) && w_done;
  assign d_valid   = (r_state == DATA) && w_done;
  assign if_rdata  = w_abort ? '0 : m_rdata;
  assign d_rdata   = w_abort ? '0 : (r_byte ? {24'h0, w_lane_byte} : m_rdata);
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = w_d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; timeout scenario runs when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_read, d_write, d_byte;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_valid;
  logic        stall_if, stall_mem;
  logic        m_req, m_we;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        err;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_read(d_read), .d_write(d_write), .d_byte(d_byte), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .m_req(m_req), .m_we(m_we), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 0; if_addr = '0; d_read = 0; d_write = 0; d_byte = 0;
    d_addr = '0; d_wdata = '0; m_ack = 0; m_rdata = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL reset_m_req got=%b exp=0", m_req); end
    checks++; if ({m_we, m_wstrb} !== 5'b0) begin failures++; $display("FAIL reset_we_strb got=%b exp=00000", {m_we, m_wstrb}); end
    checks++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin failures++; $display("FAIL reset_addr_wdata got=%h/%h exp=0/0", m_addr, m_wdata); end
    checks++; if ({err, if_valid, d_valid, stall_if, stall_mem} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {err, if_valid, d_valid, stall_if, stall_mem}); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    int stall_cnt = 0;
    int valid_cnt = 0;
    if_addr = 32'h100; m_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 6; c++) begin
      if_req = (c <= 3);
      m_ack  = (c == 3);
      @(negedge clk);
      if (stall_if) stall_cnt++;
      if (if_valid) valid_cnt++;
      if (c == 1) begin
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h100 || m_we !== 1'b0) begin failures++; $display("FAIL fetch_req got=req%b addr%h we%b exp=req1 addr100 we0", m_req, m_addr, m_we); end
      end
      if (c == 3) begin
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_data got=%b/%h exp=1/deadbeef", if_valid, if_rdata); end
      end
      if (c == 4) begin
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL fetch_drop got=%b exp=0", m_req); end
      end
      next_cycle();
    end
    m_ack = 0;
    checks++; if (stall_cnt !== 3) begin failures++; $display("FAIL fetch_stall_cycles got=%0d exp=3", stall_cnt); end
    checks++; if (valid_cnt !== 1) begin failures++; $display("FAIL fetch_valid_cycles got=%0d exp=1", valid_cnt); end
  endtask

  task automatic test_byte_store();
    d_write = 1; d_byte = 1; d_addr = 32'h203; d_wdata = 32'h000000AB; m_ack = 1;
    @(negedge clk);
    checks++; if (d_valid !== 1'b0 || stall_mem !== 1'b1) begin failures++; $display("FAIL store_c0 got=valid%b stall%b exp=valid0 stall1", d_valid, stall_mem); end
    next_cycle();
    @(negedge clk);
    checks++; if (m_addr !== 32'h200 || m_wstrb !== 4'b1000 || m_we !== 1'b1) begin failures++; $display("FAIL store_fmt got=%h/%b/%b exp=200/1000/1", m_addr, m_wstrb, m_we); end
    checks++; if (m_wdata !== 32'hABABABAB) begin failures++; $display("FAIL store_wdata got=%h exp=abababab", m_wdata); end
    checks++; if (d_valid !== 1'b1 || stall_mem !== 1'b0) begin failures++; $display("FAIL store_valid got=valid%b stall%b exp=valid1 stall0", d_valid, stall_mem); end
    next_cycle();
    d_write = 0; d_byte = 0; m_ack = 0;
    @(negedge clk);
    checks++; if (m_req !== 1'b0 || d_valid !== 1'b0) begin failures++; $display("FAIL store_idle got=req%b valid%b exp=0 0", m_req, d_valid); end
    next_cycle();
  endtask

  task automatic test_loads();
    logic [31:0] exp_rd [2];
    exp_rd[0] = 32'h00000022;
    exp_rd[1] = 32'h11223344;
    m_rdata = 32'h11223344; d_addr = 32'h302; m_ack = 1;
    for (int k = 0; k < 2; k++) begin
      d_read = 1; d_byte = (k == 0);
      next_cycle();
      @(negedge clk);
      checks++; if (d_valid !== 1'b1 || d_rdata !== exp_rd[k]) begin failures++; $display("FAIL load_%0d got=%b/%h exp=1/%h", k, d_valid, d_rdata, exp_rd[k]); end
      checks++; if (m_addr !== 32'h300 || m_wstrb !== 4'b0000 || m_we !== 1'b0) begin failures++; $display("FAIL load_fmt_%0d got=%h/%b/%b exp=300/0000/0", k, m_addr, m_wstrb, m_we); end
      next_cycle();
      d_read = 0;
      next_cycle();
    end
    m_ack = 0; d_byte = 0;
  endtask

  task automatic test_back_to_back();
    int nd = 0;
    int nf = 0;
    logic exp_d, exp_f, exp_req;
    if_req = 1; if_addr = 32'h500; d_read = 1; d_addr = 32'h400; m_ack = 1; m_rdata = 32'hCAFE0000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_req = (c % 2 == 1);
      exp_d   = (c % 4 == 1);
      exp_f   = (c % 4 == 3);
      if (d_valid) nd++;
      if (if_valid) nf++;
      checks++; if (m_req !== exp_req || d_valid !== exp_d || if_valid !== exp_f) begin failures++; $display("FAIL b2b_c%0d got=req%b d%b f%b exp=req%b d%b f%b", c, m_req, d_valid, if_valid, exp_req, exp_d, exp_f); end
      if (exp_req) begin
        checks++; if (m_addr !== (exp_d ? 32'h400 : 32'h500)) begin failures++; $display("FAIL b2b_addr_c%0d got=%h exp=%h", c, m_addr, exp_d ? 32'h400 : 32'h500); end
      end
      next_cycle();
    end
    if_req = 0; d_read = 0; m_ack = 0;
    checks++; if (nd !== 2 || nf !== 2) begin failures++; $display("FAIL b2b_counts got=d%0d f%0d exp=d2 f2", nd, nf); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    d_write = 1; d_byte = 0; d_addr = 32'h600; d_wdata = 32'h12345678; if_req = 1; if_addr = 32'h700; m_ack = 0;
    next_cycle();
    @(negedge clk);
    checks++; if (m_req !== 1'b1 || m_wdata !== 32'h12345678 || m_addr !== 32'h600) begin failures++; $display("FAIL rstmid_grant got=req%b %h %h exp=req1 12345678 600", m_req, m_wdata, m_addr); end
    next_cycle();
    rst = 1;
    @(negedge clk);
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", d_valid); end
    next_cycle();
    rst = 0;
    @(negedge clk);
    checks++; if (m_req !== 1'b0 || d_valid !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL rstmid_drop got=req%b d%b f%b exp=0 0 0", m_req, d_valid, if_valid); end
    next_cycle();
    m_ack = 1;
    @(negedge clk);
    checks++; if (m_addr !== 32'h600 || m_we !== 1'b1 || d_valid !== 1'b1) begin failures++; $display("FAIL rstmid_restart got=%h we%b d%b exp=600 we1 d1", m_addr, m_we, d_valid); end
    next_cycle();
    d_write = 0; if_req = 0; m_ack = 0;
    next_cycle();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int err_cnt = 0;
    d_read = 1; d_byte = 0; d_addr = 32'h800; m_ack = 0; m_rdata = 32'h55AA55AA;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) d_read = 0;
      @(negedge clk);
      if (err) err_cnt++;
      checks++; if (d_valid !== (c == 4)) begin failures++; $display("FAIL timeout_valid_c%0d got=%b exp=%b", c, d_valid, c == 4); end
      if (c == 4) begin
        checks++; if (d_rdata !== 32'h0) begin failures++; $display("FAIL timeout_rdata got=%h exp=0", d_rdata); end
      end
      if (c == 5) begin
        checks++; if (err !== 1'b1 || m_req !== 1'b0) begin failures++; $display("FAIL timeout_err got=err%b req%b exp=1 0", err, m_req); end
      end
      next_cycle();
    end
    checks++; if (err_cnt !== 1) begin failures++; $display("FAIL timeout_err_pulses got=%0d exp=1", err_cnt); end
  endtask
`else
  task automatic test_no_timeout();
    int err_cnt = 0;
    d_read = 1; d_byte = 0; d_addr = 32'h800; m_ack = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (err) err_cnt++;
      if (c == 9) begin
        checks++; if (m_req !== 1'b1 || d_valid !== 1'b0) begin failures++; $display("FAIL wait_forever got=req%b d%b exp=1 0", m_req, d_valid); end
      end
      next_cycle();
    end
    m_ack = 1;
    @(negedge clk);
    checks++; if (d_valid !== 1'b1 || err_cnt !== 0) begin failures++; $display("FAIL late_ack got=d%b errs%0d exp=1 0", d_valid, err_cnt); end
    next_cycle();
    d_read = 0; m_ack = 0;
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_byte_store();
    test_loads();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between instruction fetch (IF) and the MEM-stage load/store path. It arbitrates requests, runs a variable-latency req/ack transaction on the memory side, and formats byte or word accesses. It generates the IF and MEM stall signals that hold the pipeline registers while an access is pending.

## Interface
- `TIMEOUT`, default 64: cycles an access waits for `m_ack` before abort. Used only with `MEM_ARB_TIMEOUT_EN`.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request. Held until `if_valid`.
- `if_addr` in 32: fetch address. Word access; bits [1:0] ignored.
- `if_rdata` out 32: fetched instruction. Valid when `if_valid` is high.
- `if_valid` out 1: fetch completes this cycle.
- `d_read` in 1: MEM-stage load (memread). Held until `d_valid`.
- `d_write` in 1: MEM-stage store (memwrite). Held until `d_valid`. Mutually exclusive with `d_read`.
- `d_byte` in 1: memop. 1 = byte access, 0 = word access.
- `d_addr` in 32: data address (ALU result).
- `d_wdata` in 32: store data (rs2).
- `d_rdata` out 32: load data. Valid when `d_valid` is high.
- `d_valid` out 1: data access completes this cycle.
- `stall_if` out 1: hold the IF stage.
- `stall_mem` out 1: hold EX/MEM and the stages upstream of it.
- `m_req` out 1: memory request. Registered.
- `m_we` out 1: write enable. Registered.
- `m_wstrb` out 4: byte strobes. Registered.
- `m_addr` out 32: word-aligned address. Registered.
- `m_wdata` out 32: write data. Registered.
- `m_ack` in 1: memory completes the transaction. Sampled only while `m_req` is high.
- `m_rdata` in 32: read data. Valid in the ack cycle.
- `err` out 1: one-cycle timeout pulse.

## Operation
- FSM states: IDLE, DATA, FETCH.
- IDLE:
  - Arbitrates among the requests.
  - Data request present, fetch not: go to DATA.
  - Fetch present, data not: go to FETCH.
  - Both present: data wins, unless the last grant was DATA and fetch was refused at that arbitration; fetch then wins.
  - Last-grant bit resets to FETCH.
- On entry to DATA or FETCH, the `m_*` registers latch the granted request. They stay stable until completion.
- DATA or FETCH with `m_ack=1`:
  - The requester's `*_valid` is high combinationally.
  - Next state is IDLE and `m_req` drops.
  - One IDLE cycle always separates transactions, so a held request is never re-granted.
- Address and strobe formatting:
  - `m_addr` = {addr[31:2], 2'b00}.
  - Word access: `m_wstrb` = 4'b1111.
  - Byte access: `m_wstrb` = 4'b0001 << addr[1:0] and `m_wdata` = {4{d_wdata[7:0]}}.
  - Reads: `m_wstrb` = 0 and `m_we` = 0.
- Read data returned:
  - Byte load: `d_rdata` = zero-extended lane `m_rdata[8*addr[1:0] +: 8]`, using the latched addr[1:0].
  - Word load: `m_rdata` passes through.
  - `if_rdata` = `m_rdata`.
- Stall signals:
  - `stall_mem` = (`d_read` | `d_write`) & ~`d_valid`.
  - `stall_if` = `if_req` & ~`if_valid`.
- Reset values: state IDLE; `m_req`, `m_we`, `m_wstrb`, `m_addr`, `m_wdata`, `err` all 0. Combinational outputs follow from these.
- Reset mid-transaction: `m_req` is 0 from the next cycle. The memory must tolerate an abandoned request. No valid pulse is produced.

## Timing
- Request seen in IDLE at cycle 0. `m_req` goes high at cycle 1.
- A same-cycle `m_ack` at cycle 1 gives `*_valid` at cycle 1. The next arbitration is at cycle 2.
- Minimum throughput: one access per 2 cycles. Each wait cycle adds 1.
- `m_ack` while `m_req=0` is ignored.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to DATA/FETCH and counts each cycle without ack.
  - Reaching `TIMEOUT` means abort: `*_valid` is high with rdata 32'h0, `err` pulses for one cycle, and the FSM returns to IDLE.
  - An ack in the same cycle as timeout wins; no `err` pulse.
- Undefined: waits indefinitely, no counter logic, `err` tied to 0.

## Test plan
- Fetch only, `if_addr`=0x100, ack 2 cycles after `m_req` → `m_addr`=0x100, `m_we`=0, `if_valid` for 1 cycle carrying `m_rdata`, `stall_if` high for exactly 3 cycles.
- Byte store, `d_addr`=0x203, `d_wdata`=0x000000AB, zero-wait ack → `m_addr`=0x200, `m_wstrb`=4'b1000, `m_wdata`=0xABABABAB, `d_valid` in cycle 1.
- Byte load, `d_addr`=0x302, `m_rdata`=0x11223344 → `d_rdata`=0x00000022; word load at the same address → 0x11223344.
- Continuous `if_req` plus back-to-back data requests → grants alternate D,F,D,F; the IDLE gap between transactions is always 1 cycle; neither requester is starved.
- `rst` asserted 1 cycle after `m_req` rises during a DATA access → `m_req`=0 on the next cycle, no `d_valid`, arbiter restarts cleanly, last-grant = FETCH.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT`=4, no ack → after 4 cycles `d_valid`=1, `d_rdata`=0, `err` pulses once, state returns to IDLE.
